// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: sequencing controller for a shift/add style multiplier
// datapath. Loads the operand registers, runs accumulate cycles until the
// datapath count reaches zero, then presents the product until the
// consumer acknowledges it.
//
// Optional feature macro: MULT_SEQ_CTRL_WATCHDOG_EN
//   When defined, an accumulate run that reaches MAX_ITER cycles without
//   the count reaching zero is aborted into WAIT_ACK with err=1.
//   When undefined, err is tied low and ACCUM only exits on zero_n=0.
//
// Ports
//   clk          system clock, all flops on its rising edge
//   rst          synchronous active-high reset
//   start        request a multiplication (sampled in IDLE only)
//   ack          consumer has taken the result (sampled in WAIT_ACK only)
//   zero_n       datapath count-reached-zero flag, active low
//   loadbr       load multiplicand register
//   loadar       load count register
//   loadpr       load product accumulator
//   sel          count mux select (0 = multiplier, 1 = decremented count)
//   done         freeze the datapath
//   busy         operation in progress
//   result_valid product stable and readable
//   err          watchdog abort flag, qualified by result_valid
//   iter_count   number of ACCUM cycles executed, saturating
//
// State      | meaning
// -----------+-------------------------------------------------------
// IDLE       | datapath frozen, waiting for start
// LOAD       | one cycle: load multiplicand and multiplier count
// ACCUM      | accumulate and decrement count each cycle until zero
// WAIT_ACK   | product held stable, waiting for consumer ack

module mult_seq_ctrl #(
  parameter int unsigned MAX_ITER = 255,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             ack,
  input  logic             zero_n,
  output logic             loadbr,
  output logic             loadar,
  output logic             loadpr,
  output logic             sel,
  output logic             done,
  output logic             busy,
  output logic             result_valid,
  output logic             err,
  output logic [CNT_W-1:0] iter_count
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD     = 2'd1,
    ACCUM    = 2'd2,
    WAIT_ACK = 2'd3
  } state_t;

`ifdef MULT_SEQ_CTRL_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_iter;
  logic [CNT_W-1:0] w_iter_inc;
  logic             w_at_max;
  logic             w_wd_hit;
  logic             w_launch;

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  assign w_iter_inc = (r_iter == '1) ? r_iter : (r_iter + CNT_ONE);

  // Compare against the post-increment value so the abort edge lands with
  // iter_count exactly equal to MAX_ITER.
  assign w_at_max = (32'(w_iter_inc) >= MAX_ITER);

  // A real zero on the same edge wins over the watchdog (err stays 0).
  assign w_wd_hit = WD_EN & w_at_max & zero_n;

  assign w_launch = (r_state == IDLE) & start;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_iter  <= '0;
    end else begin
      r_state <= w_next;
      if (w_launch) begin
        r_iter <= '0;
      end else if (r_state == ACCUM) begin
        r_iter <= w_iter_inc;
      end
    end
  end

`ifdef MULT_SEQ_CTRL_WATCHDOG_EN
  logic r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_launch) begin
      r_err <= 1'b0;
    end else if ((r_state == ACCUM) && w_wd_hit) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign iter_count = r_iter;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next = LOAD;
        end
      end
      LOAD: begin
        w_next = ACCUM;
      end
      ACCUM: begin
        if (!zero_n || w_wd_hit) begin
          w_next = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (ack) begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Moore outputs decoded from the state register only.
  always_comb begin
    done         = 1'b1;
    loadbr       = 1'b0;
    loadar       = 1'b0;
    loadpr       = 1'b0;
    sel          = 1'b0;
    busy         = 1'b0;
    result_valid = 1'b0;
    case (r_state)
      LOAD: begin
        done   = 1'b0;
        loadbr = 1'b1;
        loadar = 1'b1;
        busy   = 1'b1;
      end
      ACCUM: begin
        done   = 1'b0;
        sel    = 1'b1;
        loadar = 1'b1;
        loadpr = 1'b1;
        busy   = 1'b1;
      end
      WAIT_ACK: begin
        result_valid = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: doc/mult_seq_ctrl.md
MULT_SEQ_CTRL -- requirements
Module: mult_seq_ctrl

Interface
REQ-001 The block SHALL have parameter MAX_ITER, default 255, giving the ACCUM-cycle limit used by the watchdog.
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the width of the iteration counter and iter_count.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset; all flops SHALL update on the rising edge of clk.
REQ-004 The block SHALL have port clk, input, 1 bit: system clock.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-006 The block SHALL have port start, input, 1 bit: request a multiplication; sampled only in IDLE.
REQ-007 The block SHALL have port ack, input, 1 bit: consumer has taken the result.
REQ-008 The block SHALL have port zero_n, input, 1 bit: datapath count-reached-zero flag, active low.
REQ-009 The block SHALL have port loadbr, output, 1 bit: load the multiplicand register.
REQ-010 The block SHALL have port loadar, output, 1 bit: load the count register.
REQ-011 The block SHALL have port loadpr, output, 1 bit: load the product accumulator.
REQ-012 The block SHALL have port sel, output, 1 bit: count mux select (0 = multiplier, 1 = decremented count).
REQ-013 The block SHALL have port done, output, 1 bit: freeze the datapath.
REQ-014 The block SHALL have port busy, output, 1 bit: operation in progress.
REQ-015 The block SHALL have port result_valid, output, 1 bit: product is stable and may be read.
REQ-016 The block SHALL have port err, output, 1 bit: watchdog abort flag, qualified by result_valid.
REQ-017 The block SHALL have port iter_count, output, CNT_W bits: number of ACCUM cycles executed.

Function
REQ-018 The FSM SHALL have exactly the states IDLE, LOAD, ACCUM and WAIT_ACK, all as registered Moore outputs.
REQ-019 IDLE SHALL drive done=1, sel=0, all load signals=0, busy=0 and result_valid=0; start=1 SHALL move the FSM to LOAD on the next edge.
REQ-020 IDLE to LOAD SHALL clear iter_count to 0 and err to 0.
REQ-021 LOAD SHALL last exactly one cycle, driving done=0, loadbr=1, loadar=1, sel=0, loadpr=0 and busy=1, then move to ACCUM.
REQ-022 ACCUM SHALL drive done=0, sel=1, loadar=1, loadpr=1, loadbr=0 and busy=1, and SHALL increment iter_count by 1 on every edge spent in ACCUM.
REQ-023 zero_n SHALL be sampled only in ACCUM; zero_n=0 SHALL move the FSM to WAIT_ACK on that edge, with that cycle's increment still applied.
REQ-024 iter_count SHALL saturate at all-ones and SHALL never wrap.
REQ-025 WAIT_ACK SHALL drive done=1, all loads=0, busy=0 and result_valid=1, and SHALL hold iter_count and err stable.
REQ-026 ack=1 in WAIT_ACK SHALL move the FSM to IDLE on the next edge; ack SHALL be ignored in all other states.
REQ-027 start SHALL be ignored outside IDLE; start and ack both high in WAIT_ACK SHALL return the FSM to IDLE without starting a new operation.
REQ-028 A start held high across the return to IDLE SHALL launch a new operation one cycle after entering IDLE.
REQ-029 Latency from start sampled to result_valid SHALL be 2 + N cycles, where N is the number of ACCUM cycles.

Reset
REQ-030 rst=1 at a rising edge SHALL force IDLE from any state, overriding start, ack and zero_n.
REQ-031 Reset SHALL set outputs to: done=1, loadbr=0, loadar=0, loadpr=0, sel=0, busy=0, result_valid=0, err=0, iter_count=0.
REQ-032 A reset during LOAD or ACCUM SHALL abort the operation without asserting result_valid.

Configuration
REQ-033 With macro MULT_SEQ_CTRL_WATCHDOG_EN defined, the ACCUM state SHALL move to WAIT_ACK with err=1 when iter_count reaches MAX_ITER and zero_n is still 1.
REQ-034 With MULT_SEQ_CTRL_WATCHDOG_EN undefined, ACCUM SHALL exit only on zero_n=0 (or on reset), and err SHALL be tied to 0.

Verification
REQ-035 A bench SHALL cover: rst, then start pulse, zero_n falls in the 3rd ACCUM cycle -> result_valid at cycle 5 after start, iter_count=3, err=0, done=1.
REQ-036 A bench SHALL cover: ack held low for 10 cycles in WAIT_ACK -> result_valid and iter_count=3 stable; ack=1 -> IDLE next edge, result_valid=0.
REQ-037 A bench SHALL cover: start pulsed during ACCUM and WAIT_ACK -> no effect on state; start and ack together in WAIT_ACK -> IDLE, busy=0.
REQ-038 A bench SHALL cover: rst asserted in the 2nd ACCUM cycle -> next edge gives done=1, all loads=0, iter_count=0, and result_valid never asserts.
REQ-039 A bench SHALL cover: WATCHDOG_EN with MAX_ITER=4 and zero_n held 1 -> WAIT_ACK after 4 ACCUM cycles, err=1, iter_count=4.
REQ-040 A bench SHALL cover: WATCHDOG_EN undefined, zero_n held 1 for 300 cycles -> stays in ACCUM, iter_count saturates at 255, err=0.
